// File: rtl/serial_mag_cmp_ctrl_if.sv
// rtl/serial_mag_cmp_ctrl_if.sv - operand/result handshake bundle for the serial magnitude comparator
interface serial_mag_cmp_ctrl_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH / 2) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic             gt;
  logic             eq;
  logic             lt;
  logic [CW-1:0]    digits;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, gt, eq, lt, digits
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, gt, eq, lt, digits
  );
endinterface

// File: rtl/serial_mag_cmp_ctrl.sv
// rtl/serial_mag_cmp_ctrl.sv - MSB-first 2-bit-per-cycle magnitude compare sequencer with early exit
module serial_mag_cmp_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  serial_mag_cmp_ctrl_if.slave   bus
);
  localparam int CW = $clog2(WIDTH / 2) + 1;
  localparam logic [CW-1:0] N_DIG   = CW'(WIDTH / 2);
  localparam logic [CW-1:0] IDX_TOP = CW'(WIDTH / 2 - 1);

  typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CW-1:0]    idx, count, dig_q;
  logic             gt_q, eq_q, lt_q;
  logic [1:0]       da, db;
  logic             gt_d, lt_d, last_digit, accept, release_res;

  // Shared 2-bit slice, fed by the digit currently selected by idx.
  always_comb begin
    da          = 2'(a_q >> {idx, 1'b0});
    db          = 2'(b_q >> {idx, 1'b0});
    gt_d        = (da[1] & ~db[1]) | ((da[1] ~^ db[1]) & da[0] & ~db[0]);
    lt_d        = (~da[1] & db[1]) | ((da[1] ~^ db[1]) & ~da[0] & db[0]);
    last_digit  = (idx == '0);
    accept      = bus.in_valid & (state == IDLE);
    release_res = bus.out_ready & (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = COMPARE;
      COMPARE: if (gt_d | lt_d | last_digit) state_nx = DONE;
      DONE:    if (release_res) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE) & ~rst;
    bus.out_valid = (state == DONE);
    bus.gt        = gt_q;
    bus.eq        = eq_q;
    bus.lt        = lt_q;
    bus.digits    = dig_q;
  end

  // Result registers are only ever nonzero while DONE, so out_valid=0 implies all-zero outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      idx   <= '0;
      count <= '0;
      gt_q  <= 1'b0;
      eq_q  <= 1'b0;
      lt_q  <= 1'b0;
      dig_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            idx   <= IDX_TOP;
            count <= CW'(1);
          end
        end
        COMPARE: begin
          if (gt_d) begin
            gt_q  <= 1'b1;
            dig_q <= count;
          end else if (lt_d) begin
            lt_q  <= 1'b1;
            dig_q <= count;
          end else if (last_digit) begin
            eq_q  <= 1'b1;
            dig_q <= N_DIG;
          end else begin
            idx   <= idx - CW'(1);
            count <= count + CW'(1);
          end
        end
        DONE: begin
          if (release_res) begin
            gt_q  <= 1'b0;
            eq_q  <= 1'b0;
            lt_q  <= 1'b0;
            dig_q <= '0;
          end
        end
        default: begin
          gt_q  <= 1'b0;
          eq_q  <= 1'b0;
          lt_q  <= 1'b0;
          dig_q <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_mag_cmp_ctrl.sv
// tb/tb_serial_mag_cmp_ctrl.sv - directed bench with a latency/arithmetic reference model
module tb_serial_mag_cmp_ctrl;
  localparam int W  = 8;
  localparam int N  = W / 2;
  localparam int CW = $clog2(N) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  serial_mag_cmp_ctrl_if #(.WIDTH(W)) bus ();

  serial_mag_cmp_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Position (1-based from MSB) of the first differing 2-bit digit; N when operands match.
  function automatic int first_diff(input int x, input int y);
    for (int k = 0; k < N; k++) begin
      int sh;
      sh = 2 * (N - 1 - k);
      if (((x >> sh) & 3) != ((y >> sh) & 3)) return k + 1;
    end
    return N;
  endfunction

  // Reference: 0 idle, 1 busy for first_diff cycles, 2 holding a result.
  int m_st = 0, m_left = 0, m_dig = 0;
  bit m_gt, m_eq, m_lt, m_init = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_st   <= 0;
      m_init <= 1'b1;
    end else begin
      case (m_st)
        0: if (bus.in_valid) begin
          m_st   <= 1;
          m_left <= first_diff(int'(bus.a), int'(bus.b));
          m_dig  <= first_diff(int'(bus.a), int'(bus.b));
          m_gt   <= bus.a > bus.b;
          m_eq   <= bus.a == bus.b;
          m_lt   <= bus.a < bus.b;
        end
        1: if (m_left == 1) m_st <= 2; else m_left <= m_left - 1;
        2: if (bus.out_ready) m_st <= 0;
        default: m_st <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      int act, exp;
      bit dn;
      dn  = (m_st == 2);
      act = {bus.in_ready, bus.out_valid, bus.gt, bus.eq, bus.lt, int'(bus.digits)} ;
      act = {26'd0, bus.in_ready, bus.out_valid, bus.gt, bus.eq, bus.lt, 1'b0} << CW | int'(bus.digits);
      exp = {26'd0, (m_st == 0) && !rst, dn, dn && m_gt, dn && m_eq, dn && m_lt, 1'b0} << CW
            | (dn ? m_dig : 0);
      chk("model", act, exp);
    end
  end

  task automatic wait_result(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic chk_result(input string tag, input bit g, input bit e, input bit l, input int d);
    chk({tag, "_valid"}, int'(bus.out_valid), 1);
    chk({tag, "_res"}, int'({bus.gt, bus.eq, bus.lt}), int'({g, e, l}));
    chk({tag, "_digits"}, int'(bus.digits), d);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_clear"}, int'({bus.out_valid, bus.gt, bus.eq, bus.lt, bus.digits}), 0);
    chk({tag, "_rdy"}, int'(bus.in_ready), 1);
  endtask

  // Starts and ends just after a rising edge.
  task automatic txn(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                     input bit g, input bit e, input bit l, input int d, input int stall);
    int lat;
    bus.a = av; bus.b = bv; bus.in_valid = 1'b1; bus.out_ready = (stall == 0);
    chk({tag, "_inrdy"}, int'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_result(lat);
    chk({tag, "_lat"}, lat, d);
    chk_result(tag, g, e, l, d);
    for (int i = 0; i < stall; i++) begin
      bus.in_valid = ~bus.in_valid;
      bus.a = 8'h00; bus.b = 8'hFF;
      @(posedge clk); #1;
      chk_result({tag, "_hold"}, g, e, l, d);
      chk({tag, "_busy"}, int'(bus.in_ready), 0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk_cleared(tag);
  endtask

  initial begin
    int lat;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.a = '0; bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", int'({bus.out_valid, bus.gt, bus.eq, bus.lt, bus.digits}), 0);
    chk("rst_inrdy", int'(bus.in_ready), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_inrdy", int'(bus.in_ready), 1);

    txn("a5_5a", 8'hA5, 8'h5A, 1, 0, 0, 1, 0);
    txn("3c_3c", 8'h3C, 8'h3C, 0, 1, 0, 4, 0);
    txn("00_00", 8'h00, 8'h00, 0, 1, 0, 4, 0);
    txn("ff_ff", 8'hFF, 8'hFF, 0, 1, 0, 4, 0);
    txn("12_13", 8'h12, 8'h13, 0, 0, 1, 4, 0);
    txn("80_7f", 8'h80, 8'h7F, 1, 0, 0, 1, 0);
    txn("34_38", 8'h34, 8'h38, 0, 0, 1, 3, 0);
    txn("bp", 8'hA5, 8'h5A, 1, 0, 0, 1, 5);

    // Busy: in_valid stays high with new operands during COMPARE; second pair waits for IDLE.
    bus.a = 8'h34; bus.b = 8'h38; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.a = 8'hFF; bus.b = 8'h00;
    chk("busy_inrdy", int'(bus.in_ready), 0);
    wait_result(lat);
    chk("busy_lat", lat, 3);
    chk_result("busy_first", 0, 0, 1, 3);
    @(posedge clk); #1;
    chk_cleared("busy_hs");
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_result(lat);
    chk("busy2_lat", lat, 1);
    chk_result("busy_second", 1, 0, 0, 1);
    @(posedge clk); #1;
    chk_cleared("busy2_hs");

    // Reset during the second COMPARE cycle drops the pair.
    bus.a = 8'h12; bus.b = 8'h13; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_inrdy", int'(bus.in_ready), 0);
    @(posedge clk); #1;
    chk("rst_mid_outs", int'({bus.out_valid, bus.gt, bus.eq, bus.lt, bus.digits}), 0);
    rst = 1'b0;
    #1;
    chk("rst_rel_inrdy", int'(bus.in_ready), 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("rst_no_result", int'(bus.out_valid), 0);
    end
    txn("40_40", 8'h40, 8'h40, 0, 1, 0, 4, 0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
